// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared widths, op encodings and buffer entry layout (p field only with LOGIC_PARITY_FLAG_EN)
package logic_unit_pkg;
    localparam int DATA_W = 16;
    localparam int REG_ADDR_W = 4;
    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_AND = 2'b11
    } logicOp_e;
    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic [REG_ADDR_W-1:0] dest;
        logic                  z;
        logic                  n;
`ifdef LOGIC_PARITY_FLAG_EN
        logic                  p;
`endif
    } bufEntry_t;
endpackage

// File: rtl/result_fifo.sv
// result_fifo: generic DEPTH-entry FIFO; count is the only full/empty discriminator, flush clears to empty
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wrData,
    output logic [WIDTH-1:0]           rdData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic doPush, doPop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign doPush = push & ~full;
    assign doPop = pop & ~empty;
    assign rdData = mem[rdPtr];
    // storage, pointers and occupancy; flush wins over push/pop, pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= wrData;
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) rdPtr <= rdPtr + AW'(1);
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end
endmodule

// File: rtl/logic_result_buffer.sv
// logic_result_buffer: in-order buffer of logic unit results with retire-time Z/N flags (flag_p under LOGIC_PARITY_FLAG_EN)
module logic_result_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH = 2,
    parameter int REG_ADDR_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_result,
    input  logic [1:0]                 in_op,
    input  logic [REG_ADDR_W-1:0]      in_dest,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_result,
    output logic [REG_ADDR_W-1:0]      out_dest,
    output logic                       flag_z,
    output logic                       flag_n,
`ifdef LOGIC_PARITY_FLAG_EN
    output logic                       flag_p,
`endif
    output logic [$clog2(DEPTH):0]     count
);
    import logic_unit_pkg::*;
    bufEntry_t inEntry, headEntry;
    logic push, pop, full, empty, started;
    assign in_ready = started & ~full;
    assign out_valid = ~empty;
    assign push = in_valid & in_ready & ~flush & (in_op != OP_NOP);
    assign pop = out_valid & out_ready & ~flush;
    assign out_result = headEntry.result;
    assign out_dest = headEntry.dest;
    // pack the incoming result with its precomputed flags
    always_comb begin
        inEntry = '0;
        inEntry.result = in_result;
        inEntry.dest = in_dest;
        inEntry.z = in_result == '0;
        inEntry.n = in_result[DATA_W-1];
`ifdef LOGIC_PARITY_FLAG_EN
        inEntry.p = ^in_result;
`endif
    end
    result_fifo #(.WIDTH($bits(bufEntry_t)), .DEPTH(DEPTH)) fifo (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .push(push),
        .pop(pop),
        .wrData(inEntry),
        .rdData(headEntry),
        .count(count),
        .full(full),
        .empty(empty)
    );
    // hold in_ready low until the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) started <= 1'b0;
        else started <= 1'b1;
    end
    // flags take the retiring entry's stored values; flush leaves them untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
`ifdef LOGIC_PARITY_FLAG_EN
            flag_p <= 1'b0;
`endif
        end else if (pop) begin
            flag_z <= headEntry.z;
            flag_n <= headEntry.n;
`ifdef LOGIC_PARITY_FLAG_EN
            flag_p <= headEntry.p;
`endif
        end
    end
endmodule

// File: tb/tb_logic_result_buffer.sv
// tb_logic_result_buffer: scoreboard bench for logic_result_buffer (flag_p checked with LOGIC_PARITY_FLAG_EN)
module tb_logic_result_buffer;
    localparam int DEPTH = 2;
    typedef struct packed {
        logic [15:0] r;
        logic [3:0]  d;
        logic        z;
        logic        n;
        logic        p;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] in_result = '0;
    logic [1:0] in_op = '0;
    logic [3:0] in_dest = '0;
    logic in_ready, out_valid, flag_z, flag_n;
    logic [15:0] out_result;
    logic [3:0] out_dest;
    logic [1:0] count;
    logic flag_p_obs;
`ifdef LOGIC_PARITY_FLAG_EN
    logic flag_p;
    assign flag_p_obs = flag_p;
`else
    assign flag_p_obs = 1'b0;
`endif
    exp_t sb[$];
    int checks = 0, errors = 0, mCount = 0;
    logic mZ = 0, mN = 0, mP = 0;

    logic_result_buffer #(.DATA_W(16), .DEPTH(DEPTH), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_op(in_op), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_dest(out_dest),
        .flag_z(flag_z), .flag_n(flag_n),
`ifdef LOGIC_PARITY_FLAG_EN
        .flag_p(flag_p),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [15:0] r, input logic [1:0] op, input logic [3:0] d, input logic rdy, input logic fl);
        in_valid = v; in_result = r; in_op = op; in_dest = d; out_ready = rdy; flush = fl;
    endtask

    // called at a negedge with inputs already driven: check state, update model, advance one cycle
    task automatic step();
        bit doPush, doPop;
        exp_t e;
        doPush = in_valid && (mCount != DEPTH) && !flush && in_op != 2'b00;
        doPop = (mCount != 0) && out_ready && !flush;
        checks++; if (in_ready !== (mCount != DEPTH)) begin errors++; $display("FAIL in_ready got %b exp %b", in_ready, mCount != DEPTH); end
        checks++; if (out_valid !== (mCount != 0)) begin errors++; $display("FAIL out_valid got %b exp %b", out_valid, mCount != 0); end
        checks++; if (count !== 2'(mCount)) begin errors++; $display("FAIL count got %0d exp %0d", count, mCount); end
        checks++; if ({flag_z, flag_n} !== {mZ, mN}) begin errors++; $display("FAIL flags_zn got %b%b exp %b%b", flag_z, flag_n, mZ, mN); end
`ifdef LOGIC_PARITY_FLAG_EN
        checks++; if (flag_p_obs !== mP) begin errors++; $display("FAIL flag_p got %b exp %b", flag_p_obs, mP); end
`endif
        if (doPop) begin
            e = sb.pop_front();
            checks++; if (out_result !== e.r || out_dest !== e.d) begin errors++; $display("FAIL head got %h/%0d exp %h/%0d", out_result, out_dest, e.r, e.d); end
            mZ = e.z; mN = e.n; mP = e.p;
        end
        if (doPush) sb.push_back('{r: in_result, d: in_dest, z: in_result == 16'h0, n: in_result[15], p: ^in_result});
        if (flush) begin mCount = 0; sb.delete(); end
        else mCount = mCount + int'(doPush) - int'(doPop);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({out_valid, count, flag_z, flag_n, flag_p_obs} !== 5'b0 || out_result !== 16'h0 || out_dest !== 4'h0) begin
            errors++; $display("FAIL reset_state got v%b c%0d z%b n%b p%b r%h d%h exp all 0", out_valid, count, flag_z, flag_n, flag_p_obs, out_result, out_dest);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", in_ready); end
    endtask

    task automatic test_single();
        drive(1, 16'h0000, 2'b01, 4'd3, 1, 0); step();
        drive(0, 16'h0, 2'b00, 4'd0, 1, 0); step();
        step();
        checks++; if ({flag_z, flag_n} !== 2'b10) begin errors++; $display("FAIL single_flags got %b%b exp 10", flag_z, flag_n); end
    endtask

    task automatic test_full();
        drive(1, 16'h8001, 2'b10, 4'd5, 0, 0); step();
        drive(1, 16'h00F0, 2'b11, 4'd6, 0, 0); step();
        checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL full_state got c%0d r%b exp c2 r0", count, in_ready); end
        drive(1, 16'h1234, 2'b01, 4'd7, 0, 0); step();
        drive(0, 16'h0, 2'b00, 4'd0, 1, 0); step();
        checks++; if ({flag_z, flag_n} !== 2'b01) begin errors++; $display("FAIL first_pop_flags got %b%b exp 01", flag_z, flag_n); end
        step();
        checks++; if ({flag_z, flag_n} !== 2'b00) begin errors++; $display("FAIL second_pop_flags got %b%b exp 00", flag_z, flag_n); end
        step();
    endtask

    task automatic test_full_push_pop();
        drive(1, 16'hA5A5, 2'b01, 4'd1, 0, 0); step();
        drive(1, 16'h0007, 2'b10, 4'd2, 0, 0); step();
        drive(1, 16'hFFFF, 2'b11, 4'd9, 1, 0); step();
        checks++; if (count !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL full_push_pop got c%0d r%b exp c1 r1", count, in_ready); end
        drive(0, 16'h0, 2'b00, 4'd0, 0, 0); step();
    endtask

    task automatic test_nop();
        drive(1, 16'h0000, 2'b00, 4'd4, 0, 0); step();
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL nop_count got %0d exp 1", count); end
        drive(0, 16'h0, 2'b00, 4'd0, 1, 0); step();
        step();
        checks++; if ({flag_z, flag_n} !== 2'b00) begin errors++; $display("FAIL nop_flags got %b%b exp 00", flag_z, flag_n); end
`ifdef LOGIC_PARITY_FLAG_EN
        checks++; if (flag_p_obs !== 1'b1) begin errors++; $display("FAIL parity_0007 got %b exp 1", flag_p_obs); end
`endif
    endtask

    task automatic test_flush();
        drive(1, 16'h8000, 2'b01, 4'd8, 1, 0); step();
        drive(0, 16'h0, 2'b00, 4'd0, 1, 0); step();
        drive(1, 16'h1111, 2'b01, 4'd1, 0, 0); step();
        drive(1, 16'h2222, 2'b01, 4'd2, 0, 0); step();
        drive(1, 16'h3333, 2'b01, 4'd3, 1, 1); step();
        checks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || {flag_z, flag_n} !== 2'b01) begin
            errors++; $display("FAIL flush got c%0d v%b r%b zn%b%b exp c0 v0 r1 zn01", count, out_valid, in_ready, flag_z, flag_n);
        end
        drive(0, 16'h0, 2'b00, 4'd0, 0, 0); step();
    endtask

    task automatic test_async_reset();
        drive(1, 16'h4444, 2'b01, 4'd4, 0, 0); step();
        drive(0, 16'h0, 2'b00, 4'd0, 0, 0);
        #2 rst = 1'b1;
        #1;
        checks++; if ({out_valid, count, flag_z, flag_n, flag_p_obs} !== 5'b0) begin
            errors++; $display("FAIL async_reset got v%b c%0d z%b n%b p%b exp all 0", out_valid, count, flag_z, flag_n, flag_p_obs);
        end
        mCount = 0; sb.delete(); mZ = 0; mN = 0; mP = 0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); @(negedge clk);
        drive(1, 16'hC003, 2'b11, 4'd12, 1, 0); step();
        drive(0, 16'h0, 2'b00, 4'd0, 1, 0); step();
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_full_push_pop();
        test_nop();
        test_flush();
        test_async_reset();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
